// File: rtl/bank_isu_credit_ctrl_if.sv
// -----------------------------------------------------------------------------
// bank_isu_credit_ctrl_if
//   Bundle between the bank issue-queue storage and its credit controller.
//   master : issue-queue side; drives enqueue/dequeue, slot state, releases.
//   slave  : credit controller; returns per-slot allow bits and counters.
//   Parameters must match those of the bank_isu_credit_ctrl it connects to.
//
//   Signals
//     iq_enqueue / iq_write_ptr   entry written this cycle, and its slot
//     enq_is_read / enq_ch_id     kind and channel of the enqueued op
//     iq_dequeue / iq_dequeue_ptr entry leaving this cycle, and its slot
//     iq_bottom_ptr               oldest slot, start point of the age scan
//     iq_valid_array              registered valid bits (excludes this
//                                 cycle's enqueue slot)
//     is_read_array, ch_id_array  per-slot read flag and channel
//     credit_release              one returned credit per channel
//     credit_allow_array          slot may issue
//     credit_num, pending_num     per-channel credit / uncredited-read counts
//     credit_err                  sticky error flag
// -----------------------------------------------------------------------------
interface bank_isu_credit_ctrl_if #(
   parameter int CH_NUM     = 4,
   parameter int PTR_WIDTH  = 4,
   parameter int CREDIT_MAX = 8
);
   localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int DEPTH = 1 << PTR_WIDTH;
   localparam int CW    = $clog2(CREDIT_MAX + 1);
   localparam int PW    = PTR_WIDTH + 1;

   logic                    iq_enqueue;
   logic [PTR_WIDTH-1:0]    iq_write_ptr;
   logic                    enq_is_read;
   logic [CH_W-1:0]         enq_ch_id;
   logic                    iq_dequeue;
   logic [PTR_WIDTH-1:0]    iq_dequeue_ptr;
   logic [PTR_WIDTH-1:0]    iq_bottom_ptr;
   logic [DEPTH-1:0]        iq_valid_array;
   logic [DEPTH-1:0]        is_read_array;
   logic [DEPTH*CH_W-1:0]   ch_id_array;
   logic [CH_NUM-1:0]       credit_release;
   logic [DEPTH-1:0]        credit_allow_array;
   logic [CH_NUM*CW-1:0]    credit_num;
   logic [CH_NUM*PW-1:0]    pending_num;
   logic                    credit_err;

   modport master (
      output iq_enqueue, iq_write_ptr, enq_is_read, enq_ch_id,
             iq_dequeue, iq_dequeue_ptr, iq_bottom_ptr,
             iq_valid_array, is_read_array, ch_id_array, credit_release,
      input  credit_allow_array, credit_num, pending_num, credit_err
   );

   modport slave (
      input  iq_enqueue, iq_write_ptr, enq_is_read, enq_ch_id,
             iq_dequeue, iq_dequeue_ptr, iq_bottom_ptr,
             iq_valid_array, is_read_array, ch_id_array, credit_release,
      output credit_allow_array, credit_num, pending_num, credit_err
   );
endinterface

// File: rtl/bank_isu_credit_ctrl.sv
// -----------------------------------------------------------------------------
// bank_isu_credit_ctrl
//   Per-channel read-credit controller for the bank issue queue. Tracks the
//   credits of each channel, marks which queue slots may issue, and hands each
//   freed credit to the oldest waiting read of its channel (age order starts
//   at iq_bottom_ptr and wraps). Waiting reads always beat a newly enqueued
//   read of the same channel; each channel grants at most once per cycle.
//
//   Ports
//     clk     clock
//     rst     reset, asynchronous, active-high
//     iq_if   bank_isu_credit_ctrl_if.slave (see the interface file)
//
//   Optional feature macro: BANK_CREDIT_BYPASS_EN
//     defined   : a credit released this cycle may be granted this cycle.
//     undefined : a released credit is grantable from the next cycle.
// -----------------------------------------------------------------------------
module bank_isu_credit_ctrl #(
   parameter int CH_NUM     = 4,
   parameter int PTR_WIDTH  = 4,
   parameter int CREDIT_MAX = 8
) (
   input logic                   clk,
   input logic                   rst,
   bank_isu_credit_ctrl_if.slave iq_if
);
   localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int DEPTH = 1 << PTR_WIDTH;
   localparam int CW    = $clog2(CREDIT_MAX + 1);
   localparam int PW    = PTR_WIDTH + 1;

   // State
   logic [DEPTH-1:0]     allow_q,  allow_d;
   logic [CW-1:0]        credit_q [CH_NUM];
   logic [CW-1:0]        credit_d [CH_NUM];
   logic [PW-1:0]        pend_q   [CH_NUM];
   logic [PW-1:0]        pend_d   [CH_NUM];
   logic                 err_q,    err_d;

   // Per-channel grant decision
   logic [DEPTH-1:0]     need;
   logic [DEPTH-1:0]     need_c   [CH_NUM];
   logic [CH_NUM-1:0]    scan_hit;
   logic [PTR_WIDTH-1:0] scan_ptr [CH_NUM];
   logic [CH_NUM-1:0]    pend_nz;
   logic [CH_NUM-1:0]    enq_c;
   logic [CH_NUM-1:0]    has_credit;
   logic [CH_NUM-1:0]    alloc;
   logic [CH_NUM-1:0]    grant_enq;

   // A slot needs a credit while it holds a read that has not been allowed.
   assign need = iq_if.iq_valid_array & iq_if.is_read_array & ~allow_q;

   // NOTE: every variable written in an always_comb gets a value on every path
   // (defaults first), otherwise the tool infers a latch to hold the old value.
   always_comb begin
      for (int c = 0; c < CH_NUM; c++) begin
         need_c[c]   = '0;
         scan_hit[c] = 1'b0;
         scan_ptr[c] = '0;
         for (int i = 0; i < DEPTH; i++) begin
            need_c[c][i] = need[i] &
                           (iq_if.ch_id_array[i*CH_W +: CH_W] == CH_W'(c));
         end
         // Oldest-first search: walk from the bottom pointer, wrapping at DEPTH.
         for (int k = 0; k < DEPTH; k++) begin
            if (!scan_hit[c] &&
                need_c[c][PTR_WIDTH'(iq_if.iq_bottom_ptr + PTR_WIDTH'(k))]) begin
               scan_hit[c] = 1'b1;
               scan_ptr[c] = iq_if.iq_bottom_ptr + PTR_WIDTH'(k);
            end
         end

         pend_nz[c] = (pend_q[c] != '0);
         enq_c[c]   = iq_if.iq_enqueue & iq_if.enq_is_read &
                      (iq_if.enq_ch_id == CH_W'(c));
`ifdef BANK_CREDIT_BYPASS_EN
         has_credit[c] = (credit_q[c] != '0) | iq_if.credit_release[c];
`else
         has_credit[c] = (credit_q[c] != '0);
`endif
         alloc[c]     = has_credit[c] & (pend_nz[c] | enq_c[c]);
         // The new read only wins when nothing of its channel is waiting.
         grant_enq[c] = alloc[c] & ~pend_nz[c];
      end
   end

   // Next state. Slot updates are ordered dequeue, enqueue, grants, so a
   // same-slot enqueue overrides the dequeue clear and a grant overrides both.
   always_comb begin
      allow_d = allow_q;
      err_d   = err_q;
      for (int c = 0; c < CH_NUM; c++) begin
         credit_d[c] = credit_q[c];
         pend_d[c]   = pend_q[c];
      end

      if (iq_if.iq_dequeue) begin
         // Leaving without ever being allowed means a credit bookkeeping error.
         if (!allow_q[iq_if.iq_dequeue_ptr]) err_d = 1'b1;
         allow_d[iq_if.iq_dequeue_ptr] = 1'b0;
      end

      if (iq_if.iq_enqueue) begin
         // Non-reads need no credit; reads start blocked until granted.
         allow_d[iq_if.iq_write_ptr] = ~iq_if.enq_is_read;
      end

      for (int c = 0; c < CH_NUM; c++) begin
         if (alloc[c]) begin
            if (pend_nz[c]) begin
               if (scan_hit[c]) allow_d[scan_ptr[c]] = 1'b1;
            end else begin
               allow_d[iq_if.iq_write_ptr] = 1'b1;
            end
         end

         pend_d[c] = pend_q[c] + PW'(enq_c[c] & ~grant_enq[c])
                               - PW'(alloc[c] & pend_nz[c]);

         // A release into a full counter is dropped and flagged.
         if (iq_if.credit_release[c] && (credit_q[c] == CW'(CREDIT_MAX)) &&
             !alloc[c]) begin
            err_d = 1'b1;
         end else begin
            credit_d[c] = credit_q[c] - CW'(alloc[c])
                                      + CW'(iq_if.credit_release[c]);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   // NOTE: the allow array is plain flops, not RAM, so it is reset with the
   // counters; no queue state may survive a reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         allow_q <= '0;
         err_q   <= 1'b0;
         for (int c = 0; c < CH_NUM; c++) begin
            credit_q[c] <= CW'(CREDIT_MAX);
            pend_q[c]   <= '0;
         end
      end else begin
         allow_q <= allow_d;
         err_q   <= err_d;
         for (int c = 0; c < CH_NUM; c++) begin
            credit_q[c] <= credit_d[c];
            pend_q[c]   <= pend_d[c];
         end
      end
   end

   // Output packing
   always_comb begin
      iq_if.credit_allow_array = allow_q;
      iq_if.credit_err         = err_q;
      iq_if.credit_num         = '0;
      iq_if.pending_num        = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         iq_if.credit_num[c*CW +: CW]  = credit_q[c];
         iq_if.pending_num[c*PW +: PW] = pend_q[c];
      end
   end

   // Invariants: the pending count mirrors the blocked reads in the queue, and
   // a credit counter never exceeds its reset value.
   always @(posedge clk) begin
      if (!rst) begin
         for (int c = 0; c < CH_NUM; c++) begin
            assert ($countones(need_c[c]) == int'(pend_q[c]));
            assert (credit_q[c] <= CW'(CREDIT_MAX));
         end
      end
   end

endmodule

// File: doc/bank_isu_credit_ctrl.md
# bank_isu_credit_ctrl

Parametrised credit controller for the bank issue queue. It tracks per-channel read credits, marks which queue entries may issue, and gives freed credits to the oldest waiting read entry of each channel. It sits between the issue-queue storage and the per-channel read return paths. Unlike the previous generation, it has a live pending count, dequeue handling, overflow detection and a configurable channel count and credit depth.

## Interface
- CH_NUM, 4, number of channels; CH_W = max(1, $clog2(CH_NUM)) is local.
- PTR_WIDTH, 4, queue pointer width; DEPTH = 1<<PTR_WIDTH is local.
- CREDIT_MAX, 8, credits per channel at reset; CW = $clog2(CREDIT_MAX+1) is local.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- iq_enqueue  in  1  an entry is written this cycle.
- iq_write_ptr  in  PTR_WIDTH  slot being written.
- enq_is_read  in  1  the enqueued op consumes a credit.
- enq_ch_id  in  CH_W  channel of the enqueued op.
- iq_dequeue  in  1  an entry leaves this cycle.
- iq_dequeue_ptr  in  PTR_WIDTH  slot leaving.
- iq_bottom_ptr  in  PTR_WIDTH  oldest slot.
- iq_valid_array  in  DEPTH  registered valid bits; these exclude the slot being enqueued this cycle.
- is_read_array  in  DEPTH  per-slot read flag.
- ch_id_array  in  DEPTH*CH_W  per-slot channel; slot i occupies [i*CH_W +: CH_W].
- credit_release  in  CH_NUM  one credit returned per channel per cycle.
- credit_allow_array  out  DEPTH  slot may issue.
- credit_num  out  CH_NUM*CW  credit counters.
- pending_num  out  CH_NUM*(PTR_WIDTH+1)  count of uncredited reads per channel.
- credit_err  out  1  sticky error flag.

## Operation
- need[i] = iq_valid_array[i] & is_read_array[i] & ~credit_allow_array[i]. need_c is need masked to slots where ch_id_array equals c.
- The scan for channel c returns the first set bit of need_c, searching from iq_bottom_ptr upward and wrapping modulo DEPTH.
- has_credit[c] = (credit_num[c] != 0).
- enq_c = iq_enqueue & enq_is_read & (enq_ch_id == c).
- alloc[c] = has_credit[c] & (pending_num[c] != 0 | enq_c). Each channel makes at most one grant per cycle.
- Grant target when pending_num[c] != 0: the scan result. Otherwise: iq_write_ptr.
- Waiting reads have priority. An enqueuing read is granted only if its channel has no pending reads.
- An enqueued non-read entry gets allow = 1 unconditionally. An enqueued read that is not granted gets allow = 0, and pending_num[c] increments.
- pending_num[c] next = Q + (enq_c & ~grant_to_enq) − (alloc[c] & pending_num[c] != 0).
- credit_num[c] next = Q − alloc[c] + credit_release[c].
- If release arrives with credit_num[c] == CREDIT_MAX and no alloc, the counter holds and credit_err is set.
- Dequeue clears allow[iq_dequeue_ptr].
- Dequeue of a slot whose allow = 0 sets credit_err; the slot is still cleared.
- Update order within a cycle: dequeue clear, then enqueue write, then grants. If enqueue and dequeue hit the same slot, the enqueue value wins.
- credit_err stays set until rst.

## Timing
- Reset values: credit_allow_array = 0, credit_num = CREDIT_MAX for every channel, pending_num = 0, credit_err = 0. Reset is honoured mid-operation; no queue state survives it.
- allow, the counters and credit_err are registered, so every effect appears one cycle after its cause.
- A released credit becomes grantable the following cycle.
- Back-to-back grants to one channel occur on consecutive cycles while credits remain.
- Invariant, checked every cycle: pending_num[c] == popcount(need_c), and credit_num[c] ≤ CREDIT_MAX.

## Configuration
- BANK_CREDIT_BYPASS_EN defined: has_credit[c] = (credit_num[c] != 0) | credit_release[c]. A release at count 0 is granted in the same cycle; the counter stays at 0 when release and alloc coincide.
- BANK_CREDIT_BYPASS_EN undefined: has_credit uses the counter only, so a released credit is usable one cycle later.

## Test plan
- Reset, then enqueue a read to ch1 at slot 3 → next cycle allow[3] = 1, credit_num[1] = 7, pending_num[1] = 0.
- Issue 9 reads to ch0 with no release → 8 are granted and the 9th has allow = 0 with pending_num[0] = 1. Release ch0 once → the waiting slot gets allow = 1 two cycles after the release (one cycle with BANK_CREDIT_BYPASS_EN), and pending_num[0] = 0.
- Wrap test: bottom = 14, pending ch2 reads at slots 1 and 15, one release → slot 15 is granted first.
- Ch0 has a pending read and a new ch0 read enqueues while 1 credit is available → the pending slot is granted, the new slot gets allow = 0, and pending_num[0] stays at 1.
- Release on ch3 at credit_num = 8 → credit_num stays 8 and credit_err = 1 until rst.
- Enqueue and dequeue the same slot in one cycle with a non-read op → allow = 1 and credit_err stays 0.
